// File: rtl/alu_cmd_issue.sv
// Command queue and issue sequencer in front of an external combinational ALU.
// Commands are queued in a FIFO, issued one at a time, and each result is held until consumed.
module alu_cmd_issue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [7:0]             cmd_a,
    input  logic [7:0]             cmd_b,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [2:0]             alu_op,
    input  logic [7:0]             alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_result,
    output logic [2:0]             rsp_op,
    output logic                   rsp_illegal,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 19;

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    state_e        state_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic          push;
    logic          pop;
    logic          load;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Never accept while full, even if the head is being popped this cycle.
    assign cmd_ready  = rst_n && (count_q < CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == StExec);
    assign fifo_count = count_q;

    // An empty FIFO can only be loaded from when a push lands on the same edge.
    assign head = (count_q == '0) ? {cmd_op, cmd_a, cmd_b} : mem_q[rd_ptr_q];

    always_comb begin
        load = 1'b0;
        case (state_q)
            StIdle:  load = (count_q != '0);
            StHold:  load = rsp_ready && ((count_q != '0) || push);
            default: load = 1'b0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_op      <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            if (load) begin
                {alu_op, alu_a, alu_b} <= head;
            end
            case (state_q)
                StIdle: begin
                    if (load) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_result  <= alu_result;
                    rsp_op      <= alu_op;
                    rsp_illegal <= (alu_op >= 3'b101);
                    rsp_valid   <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= load ? StExec : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: plays the downstream ALU and scoreboards every response
// against a queue of accepted commands evaluated with plain 8-bit arithmetic.
module tb_alu_cmd_issue;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_op;
    logic       rsp_illegal;
    logic [2:0] fifo_count;

    alu_cmd_issue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_illegal(rsp_illegal),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~a;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op, alu_a, alu_b);

    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    int          n_rsp = 0;
    bit          last_push;
    bit          last_rsp;
    logic [18:0] exp_q[$];
    logic [7:0]  got_res[$];
    logic [2:0]  got_op[$];
    logic        got_ill[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic new_cmd();
        cmd_op = 3'($urandom_range(0, 7));
        cmd_a  = 8'($urandom);
        cmd_b  = 8'($urandom);
    endtask

    task automatic clear_got();
        got_res.delete();
        got_op.delete();
        got_ill.delete();
    endtask

    // Samples handshakes just before the edge, then scoreboards just after it.
    task automatic tick();
        logic        p, r, hold;
        logic [7:0]  rr;
        logic [2:0]  ro;
        logic        ri;
        logic [18:0] alu_snap;
        logic [18:0] e;
        logic [18:0] x;
        #1;
        p        = cmd_valid && cmd_ready;
        r        = rsp_valid && rsp_ready;
        hold     = rsp_valid && !rsp_ready;
        rr       = rsp_result;
        ro       = rsp_op;
        ri       = rsp_illegal;
        alu_snap = {alu_op, alu_a, alu_b};
        e        = {cmd_op, cmd_a, cmd_b};
        @(posedge clk);
        #1;
        last_push = p;
        last_rsp  = r;
        if (p) begin
            exp_q.push_back(e);
            n_acc++;
        end
        if (r) begin
            n_rsp++;
            got_res.push_back(rr);
            got_op.push_back(ro);
            got_ill.push_back(ri);
            check("rsp_pending", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("rsp_result", 32'(rr), 32'(alu_ref(x[18:16], x[15:8], x[7:0])));
                check("rsp_op", 32'(ro), 32'(x[18:16]));
                check("rsp_illegal", 32'(ri), 32'(x[18:16] > 3'd4));
            end
        end
        if (hold) begin
            check("hold_valid", 32'(rsp_valid), 32'(1));
            check("hold_result", 32'(rsp_result), 32'(rr));
            check("hold_op", 32'(rsp_op), 32'(ro));
            check("hold_illegal", 32'(rsp_illegal), 32'(ri));
            check("hold_alu", 32'({alu_op, alu_a, alu_b}), 32'(alu_snap));
        end
    endtask

    task automatic drain(input string tag);
        int k = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid) && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'(0));
        check({tag, "_count0"}, 32'(fifo_count), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int ridx[$];
        int a0;
        int r0;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_fifo_count", 32'(fifo_count), 32'(0));
        check("rst_rsp_result", 32'(rsp_result), 32'(0));
        check("rst_rsp_op", 32'(rsp_op), 32'(0));
        check("rst_rsp_illegal", 32'(rsp_illegal), 32'(0));
        check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'(0));
        cmd_valid = 1'b1;
        #4;
        check("rst_no_push", 32'(fifo_count), 32'(0));
        #1;
        rst_n = 1'b1;

        // ADD latency; first push lands on the first edge after reset release.
        cmd_op = 3'd0; cmd_a = 8'd10; cmd_b = 8'd20; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("add_first_push", 32'(last_push), 32'(1));
        check("add_count1", 32'(fifo_count), 32'(1));
        check("add_valid_n", 32'(rsp_valid), 32'(0));
        tick();
        check("add_alu_a", 32'(alu_a), 32'(10));
        check("add_alu_b", 32'(alu_b), 32'(20));
        check("add_alu_op", 32'(alu_op), 32'(0));
        check("add_valid_n1", 32'(rsp_valid), 32'(0));
        tick();
        check("add_valid_n2", 32'(rsp_valid), 32'(1));
        check("add_result", 32'(rsp_result), 32'(30));
        check("add_op", 32'(rsp_op), 32'(0));
        check("add_illegal", 32'(rsp_illegal), 32'(0));
        tick();
        check("add_valid_clr", 32'(rsp_valid), 32'(0));
        drain("add");

        // SUB with modulo-256 wrap, in order.
        clear_got();
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'd30; cmd_b = 8'd10;
        tick();
        cmd_a = 8'd10; cmd_b = 8'd30;
        tick();
        drain("sub");
        check("sub_count", 32'(got_res.size()), 32'(2));
        if (got_res.size() >= 2) begin
            check("sub_first", 32'(got_res[0]), 32'(20));
            check("sub_second", 32'(got_res[1]), 32'(236));
        end

        // Illegal opcode followed by NOT A.
        clear_got();
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 8'h55; cmd_b = 8'hAA;
        tick();
        cmd_op = 3'd4; cmd_a = 8'h0C; cmd_b = 8'h00;
        tick();
        drain("ill");
        check("ill_count", 32'(got_res.size()), 32'(2));
        if (got_res.size() >= 2) begin
            check("ill_result", 32'(got_res[0]), 32'(0));
            check("ill_op", 32'(got_op[0]), 32'(7));
            check("ill_flag", 32'(got_ill[0]), 32'(1));
            check("not_result", 32'(got_res[1]), 32'(8'hF3));
            check("not_flag", 32'(got_ill[1]), 32'(0));
        end

        // Backpressure: one held plus DEPTH queued; also push+pop at count 2.
        rsp_ready = 1'b0; cmd_valid = 1'b1; new_cmd();
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (last_push) begin
                acc++;
                new_cmd();
            end
            if (i == 1) check("bp_count_before", 32'(fifo_count), 32'(2));
            if (i == 2) begin
                check("simul_push", 32'(last_push), 32'(1));
                check("simul_count", 32'(fifo_count), 32'(2));
            end
        end
        check("bp_accepted", 32'(acc), 32'(5));
        check("bp_ready", 32'(cmd_ready), 32'(0));
        check("bp_count", 32'(fifo_count), 32'(4));
        check("bp_valid", 32'(rsp_valid), 32'(1));
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 30 && ridx.size() < 5; i++) begin
            tick();
            if (last_rsp) ridx.push_back(i);
        end
        check("bp_rsp_count", 32'(ridx.size()), 32'(5));
        for (int j = 1; j < ridx.size(); j++) begin
            check("bp_interval", 32'(ridx[j] - ridx[j-1]), 32'(2));
        end
        drain("bp");

        // Pointer wrap: nine commands through the queue.
        clear_got();
        acc = 0; cmd_valid = 1'b1; rsp_ready = 1'b1; new_cmd();
        for (int i = 0; i < 60 && acc < 9; i++) begin
            tick();
            if (last_push) begin
                acc++;
                new_cmd();
            end
        end
        cmd_valid = 1'b0;
        check("wrap_accepted", 32'(acc), 32'(9));
        drain("wrap");
        check("wrap_rsp_count", 32'(got_res.size()), 32'(9));

        // Reset while holding a response with three queued.
        rsp_ready = 1'b0; cmd_valid = 1'b1; new_cmd();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (last_push) new_cmd();
        end
        cmd_valid = 1'b0;
        check("hr_count", 32'(fifo_count), 32'(3));
        check("hr_valid", 32'(rsp_valid), 32'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("hr_async_valid", 32'(rsp_valid), 32'(0));
        check("hr_async_count", 32'(fifo_count), 32'(0));
        check("hr_async_ready", 32'(cmd_ready), 32'(0));
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("hr_no_stale", 32'(rsp_valid), 32'(0));
        end
        check("hr_ready", 32'(cmd_ready), 32'(1));

        // Randomized traffic.
        a0 = n_acc; r0 = n_rsp;
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            new_cmd();
            tick();
        end
        drain("rand");
        check("rand_conserved", 32'(n_rsp - r0), 32'(n_acc - a0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issue.md
ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: cmd_valid  input  1  upstream command present.
REQ-005 Port: cmd_ready  output  1  block can accept a command this cycle.
REQ-006 Port: cmd_op  input  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A; 101-111 illegal).
REQ-007 Port: cmd_a, cmd_b  input  8 each  operands.
REQ-008 Port: alu_a, alu_b  output  8 each  operands driven to the downstream combinational ALU.
REQ-009 Port: alu_op  output  3  opcode driven to the ALU.
REQ-010 Port: alu_result  input  8  combinational ALU result for alu_a/alu_b/alu_op.
REQ-011 Port: rsp_valid  output  1  response held for consumer.
REQ-012 Port: rsp_ready  input  1  consumer accepts response.
REQ-013 Port: rsp_result  output  8  captured ALU result.
REQ-014 Port: rsp_op  output  3  opcode that produced rsp_result.
REQ-015 Port: rsp_illegal  output  1  rsp_op was 101-111.
REQ-016 Port: fifo_count  output  $clog2(DEPTH)+1  entries currently queued.

Function
REQ-017 Push occurs when cmd_valid and cmd_ready are both 1 at a clock edge; {op,a,b} written at write pointer.
REQ-018 cmd_ready SHALL equal (fifo_count < DEPTH) and SHALL be 0 while rst_n is low; no bypass when full, even if a pop occurs the same cycle.
REQ-019 Read/write pointers SHALL wrap from DEPTH-1 to 0; simultaneous push and pop leaves fifo_count unchanged.
REQ-020 FSM states: IDLE, EXEC, HOLD.
REQ-021 IDLE: if fifo_count>0 go to EXEC next edge, else stay.
REQ-022 EXEC (exactly one cycle): alu_a/alu_b/alu_op driven registered from FIFO head; at end of cycle capture alu_result into rsp_result, head op into rsp_op, set rsp_illegal=(op>=101), pop FIFO, set rsp_valid=1, go to HOLD.
REQ-023 HOLD: rsp_valid=1, rsp_result/rsp_op/rsp_illegal stable; on rsp_valid&&rsp_ready edge clear rsp_valid and go to EXEC if FIFO non-empty (counting a same-edge push), else IDLE.
REQ-024 Latency: command accepted at edge N with empty FIFO and IDLE -> EXEC cycle N+1 -> rsp_valid high after edge N+2; throughput one response per two cycles.
REQ-025 alu_a/alu_b/alu_op SHALL be loaded from the FIFO head on entry to EXEC and held unchanged in IDLE and HOLD.
REQ-026 Arithmetic is owned by the ALU: results are 8-bit modulo 256, no carry/borrow output; illegal ops yield result 0 and rsp_illegal=1; the block never drops or reorders commands.
REQ-027 rsp_valid, once set, SHALL NOT deassert without rsp_ready (except reset).

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, pointers 0, fifo_count 0, cmd_ready 0, rsp_valid 0, rsp_result 0, rsp_op 0, rsp_illegal 0, alu_a 0, alu_b 0, alu_op 0.
REQ-029 Reset asserted mid-operation (EXEC or HOLD) discards all queued and held commands; no response is emitted for them.
REQ-030 First push possible on the first edge after rst_n deasserts.

Verification
REQ-031 ADD: push op=000 a=10 b=20, rsp_ready=1 -> rsp_valid high two edges later, rsp_result=30, rsp_op=000, rsp_illegal=0.
REQ-032 SUB wrap: push 001/30/10 then 001/10/30 -> responses 20 then 236 (0xEC), in order.
REQ-033 Backpressure: rsp_ready=0, cmd_valid held with DEPTH=4 -> exactly 5 commands accepted (1 held in response, 4 queued), cmd_ready=0, fifo_count=4; release rsp_ready -> all 5 responses in push order, one per two cycles.
REQ-034 Illegal op: push 111/0x55/0xAA -> rsp_result=0, rsp_op=111, rsp_illegal=1; next legal command 100/0x0C -> rsp_result=0xF3, rsp_illegal=0.
REQ-035 Reset in HOLD with fifo_count=3 -> asynchronously rsp_valid=0, fifo_count=0, cmd_ready=0; after release no stale response appears and cmd_ready=1.
REQ-036 Simultaneous push and pop at fifo_count=2 -> fifo_count stays 2; pointer wrap exercised by pushing 9 commands through DEPTH=4 with correct ordering.
